// File: rtl/jtdd_rom_arb.sv
// Shares one read-only memory port among the char, scroll and object fetchers.
// Fixed priority char > scroll > object; each port keeps a one-byte cache.
module jtdd_rom_arb #(
  parameter int unsigned CHAR_AW = 15,
  parameter int unsigned SCR_AW  = 17,
  parameter int unsigned OBJ_AW  = 18,
  parameter int unsigned MEM_AW  = 22,
  parameter logic [MEM_AW-1:0] CHAR_OFFSET = MEM_AW'(22'h00000),
  parameter logic [MEM_AW-1:0] SCR_OFFSET  = MEM_AW'(22'h08000),
  parameter logic [MEM_AW-1:0] OBJ_OFFSET  = MEM_AW'(22'h28000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_AW-1:0] char_addr,
  input  logic              char_cs,
  output logic [7:0]        char_data,
  output logic              char_ok,
  input  logic [SCR_AW-1:0] scr_addr,
  input  logic              scr_cs,
  output logic [7:0]        scr_data,
  output logic              scr_ok,
  input  logic [OBJ_AW-1:0] obj_addr,
  input  logic              obj_cs,
  output logic [7:0]        obj_data,
  output logic              obj_ok,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  input  logic [7:0]        mem_data,
  input  logic              mem_rdy
);

  localparam int unsigned SNAP_W = (CHAR_AW > SCR_AW) ?
                                   ((CHAR_AW > OBJ_AW) ? CHAR_AW : OBJ_AW) :
                                   ((SCR_AW  > OBJ_AW) ? SCR_AW  : OBJ_AW);
  localparam int unsigned GNT_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [GNT_W-1:0] GNT_CHAR = 2'd0;
  localparam logic [GNT_W-1:0] GNT_SCR  = 2'd1;
  localparam logic [GNT_W-1:0] GNT_OBJ  = 2'd2;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [GNT_W-1:0]   r_gnt;
  logic [SNAP_W-1:0]  r_snap_addr;

  logic [CHAR_AW-1:0] r_char_cached;
  logic [7:0]         r_char_data;
  logic               r_char_valid;
  logic [SCR_AW-1:0]  r_scr_cached;
  logic [7:0]         r_scr_data;
  logic               r_scr_valid;
  logic [OBJ_AW-1:0]  r_obj_cached;
  logic [7:0]         r_obj_data;
  logic               r_obj_valid;

  logic               w_char_pend;
  logic               w_scr_pend;
  logic               w_obj_pend;
  logic               w_grant;
  logic               w_done;
  logic [GNT_W-1:0]   w_sel_gnt;
  logic [SNAP_W-1:0]  w_sel_addr;
  logic [MEM_AW-1:0]  w_sel_mem_addr;

  // A port hits when its cached byte matches the address it is presenting now
  assign char_ok   = char_cs && r_char_valid && (char_addr == r_char_cached);
  assign scr_ok    = scr_cs  && r_scr_valid  && (scr_addr  == r_scr_cached);
  assign obj_ok    = obj_cs  && r_obj_valid  && (obj_addr  == r_obj_cached);
  assign char_data = r_char_data;
  assign scr_data  = r_scr_data;
  assign obj_data  = r_obj_data;

  assign w_char_pend = char_cs && !char_ok;
  assign w_scr_pend  = scr_cs  && !scr_ok;
  assign w_obj_pend  = obj_cs  && !obj_ok;

  // Priority select of the port to grant
  always_comb begin
    w_sel_gnt      = GNT_OBJ;
    w_sel_addr     = SNAP_W'(obj_addr);
    w_sel_mem_addr = MEM_AW'(obj_addr) + OBJ_OFFSET;
    if (w_char_pend) begin
      w_sel_gnt      = GNT_CHAR;
      w_sel_addr     = SNAP_W'(char_addr);
      w_sel_mem_addr = MEM_AW'(char_addr) + CHAR_OFFSET;
    end else if (w_scr_pend) begin
      w_sel_gnt      = GNT_SCR;
      w_sel_addr     = SNAP_W'(scr_addr);
      w_sel_mem_addr = MEM_AW'(scr_addr) + SCR_OFFSET;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_char_pend || w_scr_pend || w_obj_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rdy) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt         <= GNT_CHAR;
      r_snap_addr   <= '0;
      mem_addr      <= '0;
      mem_req       <= 1'b0;
      r_char_cached <= '0;
      r_char_data   <= '0;
      r_char_valid  <= 1'b0;
      r_scr_cached  <= '0;
      r_scr_data    <= '0;
      r_scr_valid   <= 1'b0;
      r_obj_cached  <= '0;
      r_obj_data    <= '0;
      r_obj_valid   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt       <= w_sel_gnt;
        r_snap_addr <= w_sel_addr;
        mem_addr    <= w_sel_mem_addr;
        mem_req     <= 1'b1;
      end
      // Data is filed against the address snapped at grant time
      if (w_done) begin
        mem_req <= 1'b0;
        case (r_gnt)
          GNT_CHAR: begin
            r_char_data   <= mem_data;
            r_char_cached <= r_snap_addr[CHAR_AW-1:0];
            r_char_valid  <= 1'b1;
          end
          GNT_SCR: begin
            r_scr_data   <= mem_data;
            r_scr_cached <= r_snap_addr[SCR_AW-1:0];
            r_scr_valid  <= 1'b1;
          end
          GNT_OBJ: begin
            r_obj_data   <= mem_data;
            r_obj_cached <= r_snap_addr[OBJ_AW-1:0];
            r_obj_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Scoreboard bench for jtdd_rom_arb: expected memory addresses are queued as
// requests are set up and checked when the arbiter raises mem_req.
module tb_jtdd_rom_arb;

  logic        clk;
  logic        rst;
  logic [14:0] char_addr;
  logic        char_cs;
  logic [7:0]  char_data;
  logic        char_ok;
  logic [16:0] scr_addr;
  logic        scr_cs;
  logic [7:0]  scr_data;
  logic        scr_ok;
  logic [17:0] obj_addr;
  logic        obj_cs;
  logic [7:0]  obj_data;
  logic        obj_ok;
  logic [21:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_data;
  logic        mem_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [21:0] exp_q[$];
  logic [21:0] cur_addr;

  jtdd_rom_arb dut (
    .clk(clk), .rst(rst),
    .char_addr(char_addr), .char_cs(char_cs), .char_data(char_data), .char_ok(char_ok),
    .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data), .mem_rdy(mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents model
  function automatic logic [7:0] mem_fn(input logic [21:0] a);
    return a[7:0] ^ 8'h86;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("req_timeout", 32'(n < 50), 32'd1);
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      cur_addr = exp_q.pop_front();
      check("mem_addr", 32'(mem_addr), 32'(cur_addr));
    end
  endtask

  task automatic respond(input int lat);
    repeat (lat) begin
      step();
      check("req_hold", 32'(mem_req), 32'd1);
      check("addr_hold", 32'(mem_addr), 32'(cur_addr));
    end
    mem_data = mem_fn(cur_addr);
    mem_rdy  = 1'b1;
    step();
    mem_rdy  = 1'b0;
    mem_data = 8'h00;
    check("req_drop", 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    char_addr = 15'h0123; char_cs = 1'b1;
    scr_addr  = 17'h00010; scr_cs = 1'b1;
    obj_addr  = 18'h00020; obj_cs = 1'b1;
    mem_data = 8'h00; mem_rdy = 1'b0;
    cur_addr = '0;

    // Reset with everything requesting
    repeat (2) begin
      step();
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_char_ok", 32'(char_ok), 32'd0);
      check("rst_scr_ok", 32'(scr_ok), 32'd0);
      check("rst_obj_ok", 32'(obj_ok), 32'd0);
      check("rst_data", 32'({char_data, scr_data, obj_data}), 32'd0);
    end
    rst = 1'b0;
    step();
    check("lat_req", 32'(mem_req), 32'd1);

    // Char first, then scroll, char re-request during scroll wait beats obj
    exp_q.push_back(22'h000123);
    exp_q.push_back(22'h008010);
    wait_req();
    respond(4);
    check("char_data", 32'(char_data), 32'h0000_00A5);
    check("char_ok", 32'(char_ok), 32'd1);
    step();
    check("gap_req", 32'(mem_req), 32'd1);
    wait_req();
    char_addr = 15'h0124;
    respond(3);
    check("scr_data", 32'(scr_data), 32'(mem_fn(22'h008010)));
    check("scr_ok", 32'(scr_ok), 32'd1);
    check("char_miss", 32'(char_ok), 32'd0);
    exp_q.push_back(22'h000124);
    exp_q.push_back(22'h028020);
    wait_req();
    respond(2);
    check("char_data2", 32'(char_data), 32'(mem_fn(22'h000124)));
    wait_req();
    respond(1);
    check("obj_data", 32'(obj_data), 32'(mem_fn(22'h028020)));
    check("obj_ok", 32'(obj_ok), 32'd1);

    // Cached hit, no memory traffic
    step();
    check("hit_char_ok", 32'(char_ok), 32'd1);
    check("hit_no_req", 32'(mem_req), 32'd0);

    // Object address changes mid-fetch
    obj_addr = 18'h00100;
    exp_q.push_back(22'h028100);
    wait_req();
    obj_addr = 18'h00101;
    respond(3);
    check("chg_obj_ok", 32'(obj_ok), 32'd0);
    check("chg_obj_data", 32'(obj_data), 32'(mem_fn(22'h028100)));
    check("chg_char_kept", 32'(char_data), 32'(mem_fn(22'h000124)));
    exp_q.push_back(22'h028101);
    wait_req();
    respond(2);
    check("chg_obj_ok2", 32'(obj_ok), 32'd1);
    check("chg_obj_data2", 32'(obj_data), 32'(mem_fn(22'h028101)));

    // Scroll cs dropped mid-fetch
    scr_addr = 17'h00011;
    exp_q.push_back(22'h008011);
    wait_req();
    scr_cs = 1'b0;
    respond(2);
    check("cs_scr_ok", 32'(scr_ok), 32'd0);
    check("cs_scr_data", 32'(scr_data), 32'(mem_fn(22'h008011)));
    scr_cs = 1'b1;
    #1;
    check("cs_scr_ok2", 32'(scr_ok), 32'd1);
    step();
    check("cs_no_req", 32'(mem_req), 32'd0);

    // Stray mem_rdy while idle
    mem_data = 8'hEE;
    mem_rdy  = 1'b1;
    step();
    mem_rdy  = 1'b0;
    mem_data = 8'h00;
    check("stray_char", 32'(char_data), 32'(mem_fn(22'h000124)));
    check("stray_scr", 32'(scr_data), 32'(mem_fn(22'h008011)));
    check("stray_obj", 32'(obj_data), 32'(mem_fn(22'h028101)));
    check("stray_req", 32'(mem_req), 32'd0);
    check("stray_addr", 32'(mem_addr), 32'(cur_addr));
    check("stray_oks", 32'({char_ok, scr_ok, obj_ok}), 32'd7);

    // Reset during WAIT, late mem_rdy ignored
    char_addr = 15'h0200;
    exp_q.push_back(22'h000200);
    wait_req();
    rst = 1'b1;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    step();
    rst = 1'b0;
    check("rw_req", 32'(mem_req), 32'd0);
    check("rw_addr", 32'(mem_addr), 32'd0);
    check("rw_data", 32'({char_data, scr_data, obj_data}), 32'd0);
    mem_data = 8'h55;
    mem_rdy  = 1'b1;
    step();
    mem_rdy  = 1'b0;
    mem_data = 8'h00;
    check("rw_late_data", 32'({char_data, scr_data, obj_data}), 32'd0);
    check("rw_late_req", 32'(mem_req), 32'd0);
    char_cs = 1'b1;
    #1;
    check("rw_invalid", 32'(char_ok), 32'd0);
    exp_q.push_back(22'h000200);
    wait_req();
    respond(1);
    check("rw_refetch_ok", 32'(char_ok), 32'd1);
    check("rw_refetch_data", 32'(char_data), 32'(mem_fn(22'h000200)));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtdd_rom_arb.md
Name: jtdd_rom_arb

Overview:
- Shares one read-only SDRAM/ROM port among three graphics fetchers: char layer, scroll layer, object engine.
- Each fetcher drives an address and chip select. It receives data plus an "ok" flag that is high when the data matches the address currently presented.
- Sits between the video layer blocks and the SDRAM controller.
- Fixed priority: char > scroll > object. The char layer re-fetches every 2 pixels and must never be stalled behind the slower layers.

Parameters:
- CHAR_AW, 15, char requester address width (bytes)
- SCR_AW, 17, scroll requester address width
- OBJ_AW, 18, object requester address width
- MEM_AW, 22, memory port address width
- CHAR_OFFSET, 22'h00000, byte offset of char region in memory
- SCR_OFFSET, 22'h08000, byte offset of scroll region
- OBJ_OFFSET, 22'h28000, byte offset of object region

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- char_addr  in  CHAR_AW  char fetch address
- char_cs  in  1  char request enable
- char_data  out  8  char fetched byte
- char_ok  out  1  char_data valid for char_addr
- scr_addr  in  SCR_AW  scroll fetch address
- scr_cs  in  1  scroll request enable
- scr_data  out  8  scroll fetched byte
- scr_ok  out  1  scr_data valid for scr_addr
- obj_addr  in  OBJ_AW  object fetch address
- obj_cs  in  1  object request enable
- obj_data  out  8  object fetched byte
- obj_ok  out  1  obj_data valid for obj_addr
- mem_addr  out  MEM_AW  memory read address
- mem_req  out  1  memory read request (level)
- mem_data  in  8  memory read data
- mem_rdy  in  1  one-cycle pulse: mem_data valid for mem_addr

Behaviour:
- Per-port registers: cached_addr, data, valid.
- x_ok is combinational: x_cs && valid && (x_addr == cached_addr).
- pending_x = x_cs && !x_ok.
- x_data always shows the data register, whatever the state of cs.
- Reset (synchronous):
  - state=IDLE, mem_req=0, mem_addr=0.
  - All data=0, valid=0, cached_addr=0; all ok=0.
  - Reset during WAIT abandons the transfer. A mem_rdy arriving after reset is ignored.
- FSM states: IDLE, WAIT.
- IDLE:
  - If any pending_x, grant the highest-priority pending port (char > scr > obj).
  - Register gnt and snap_addr = x_addr.
  - mem_addr <= zero-extended x_addr + X_OFFSET, sum taken mod 2^MEM_AW.
  - mem_req <= 1; next state WAIT.
  - No pending port: stay in IDLE, mem_req=0.
  - mem_rdy in IDLE is ignored.
- WAIT:
  - mem_req and mem_addr held stable until mem_rdy.
  - On mem_rdy: granted port's data <= mem_data, cached_addr <= snap_addr, valid <= 1; mem_req <= 0; next state IDLE.
  - Requests arriving in WAIT are not granted, even from higher priority; there is no preemption.
- Latency:
  - New address presented at cycle 0 (arbiter idle): mem_req=1 from cycle 1.
  - mem_rdy at cycle N: x_data and x_ok valid at cycle N+1.
  - Earliest next grant decision at N+1; next mem_req at N+2. At least one idle cycle separates requests.
- Address changed during fetch: the completed data is stored against snap_addr. x_ok stays 0 because of the mismatch, and the port re-requests in IDLE. No data is written to another port.
- cs deasserted during fetch: the transfer completes and is stored. ok stays 0 until cs returns with the matching address.
- Simultaneous pending on all three ports: char is served first. The object port waits as long as char or scroll keep missing; there is no starvation guard.
- Cached hit: re-presenting cached_addr with cs=1 gives ok=1 the same cycle, with no memory access.

Test Plan:
- Reset:
  - Stimulus: rst for 2 cycles, all cs=1.
  - Response: mem_req=0, all ok=0, all data=0 during reset.
  - Response: char is the first grant after reset.
- Single fetch:
  - Stimulus: char_cs=1, char_addr=15'h0123; mem_rdy 4 cycles after mem_req with mem_data=8'hA5.
  - Response: mem_addr=22'h000123; next cycle char_data=8'hA5, char_ok=1.
  - Response: re-presenting 0x0123 later gives ok=1 with no mem_req.
- Offset and priority:
  - Stimulus: scr_addr=17'h00010 and obj_addr=18'h00020 both pending.
  - Response: first mem_addr=22'h08010, then 22'h28020.
  - Stimulus: char request raised during the scroll WAIT.
  - Response: char is served before obj.
- Address change mid-fetch:
  - Stimulus: obj_addr changes 0x100 -> 0x101 while in WAIT.
  - Response: after mem_rdy, obj_ok=0; a new mem_req with mem_addr=22'h28101 follows.
- Reset mid-WAIT:
  - Stimulus: assert rst during WAIT, then pulse mem_rdy after reset.
  - Response: state IDLE, no data written, valid=0.
- Stray mem_rdy:
  - Stimulus: mem_rdy pulse in IDLE with no request pending.
  - Response: no register changes.
